// File: rtl/rom_fetch_arbiter_if.sv
// rom_fetch_arbiter_if: one requester port of the ROM fetch arbiter.
//   req/addr/rready  requester -> arbiter
//   gnt/rvalid/rdata arbiter -> requester
// The requester side uses modport master. The arbiter side uses modport slave.
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rready;

    modport master (output req, addr, rready, input gnt, rvalid, rdata);
    modport slave  (input req, addr, rready, output gnt, rvalid, rdata);
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: arbitrates the single read port of the 64x32 instruction
// ROM between the core fetch port (I) and the debug/trace port (D).
// The ROM read has 1-cycle latency. Each response is returned on the owning
// port in the cycle after its grant, and is held until the requester accepts it.
//   clk, rst_n  clock (also clocks the ROM) and async active-low reset
//   i_port      I requester (slave modport of rom_fetch_arbiter_if)
//   d_port      D requester (slave modport of rom_fetch_arbiter_if)
//   rom_addr    ROM read address (combinational)
//   rom_dout    ROM registered read data
// Optional feature: define ROM_ARB_RR_EN for round-robin conflict resolution.
// When it is not defined, I has fixed priority.
module rom_fetch_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_fetch_arbiter_if.slave i_port,
    rom_fetch_arbiter_if.slave d_port,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_dout
);
    localparam int NP = 2;  // port 0 = I, port 1 = D

    logic [NP-1:0]             req, rready, rvalid, free, elig, gnt;
    logic [NP-1:0]             pend, hold_vld;
    logic [NP-1:0][ADDR_W-1:0] addr;
    logic [NP-1:0][DATA_W-1:0] hold_q, rdata;
    logic [ADDR_W-1:0]         last_addr;
    logic                      i_wins;

    assign req    = {d_port.req,    i_port.req};
    assign rready = {d_port.rready, i_port.rready};
    assign addr   = {d_port.addr,   i_port.addr};

    assign i_port.gnt    = gnt[0];
    assign d_port.gnt    = gnt[1];
    assign i_port.rvalid = rvalid[0];
    assign d_port.rvalid = rvalid[1];
    assign i_port.rdata  = rdata[0];
    assign d_port.rdata  = rdata[1];

    // The response slot frees up in the cycle its current response is accepted.
    // This allows a hand-off and a new grant in the same cycle.
    assign rvalid = pend | hold_vld;
    assign free   = ~rvalid | rready;
    assign elig   = req & free;

`ifdef ROM_ARB_RR_EN
    // last_d = 1 means D was granted most recently. I wins the next conflict.
    logic last_d;
    assign i_wins = ~elig[1] | last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_d <= 1'b1;
        else if (|gnt)   last_d <= gnt[1];
    end
`else
    assign i_wins = 1'b1;
`endif

    assign gnt[0] = elig[0] & i_wins;
    assign gnt[1] = elig[1] & ~gnt[0];

    // With no grant, re-present the last address so that rom_dout stays stable.
    always_comb begin
        rom_addr = last_addr;
        if (gnt[0])      rom_addr = addr[0];
        else if (gnt[1]) rom_addr = addr[1];
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NP; p++) begin
            if (hold_vld[p])  rdata[p] = hold_q[p];
            else if (pend[p]) rdata[p] = rom_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            hold_vld  <= '0;
            hold_q    <= '0;
            last_addr <= '0;
        end else begin
            pend <= gnt;
            if (|gnt) last_addr <= rom_addr;
            for (int p = 0; p < NP; p++) begin
                // rom_dout is valid only in the cycle after the grant.
                // Capture it there if the requester stalls.
                if (pend[p] && !rready[p]) begin
                    hold_vld[p] <= 1'b1;
                    hold_q[p]   <= rom_dout;
                end else if (rvalid[p] && rready[p]) begin
                    // A grant landing in this cycle sets pend, which keeps rvalid up.
                    hold_vld[p] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [DATA_W-1:0] rom [64];

    rom_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ip ();
    rom_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dp ();

    rom_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_port(ip), .d_port(dp),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int tests = 0;
    int fails = 0;

    // Reference model: each port holds an outstanding word or nothing.
    // The expected data is simply the ROM contents at the granted address.
    bit                busy [2];
    logic [DATA_W-1:0] exp_d [2];
    logic [ADDR_W-1:0] m_last;
    bit                m_last_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy[0] = 0; busy[1] = 0;
        exp_d[0] = '0; exp_d[1] = '0;
        m_last = '0; m_last_d = 1'b1;
    endtask

    task automatic drive(input bit ir, input int ia, input bit irr,
                         input bit dr, input int da, input bit drr);
        ip.req = ir; ip.addr = ADDR_W'(ia); ip.rready = irr;
        dp.req = dr; dp.addr = ADDR_W'(da); dp.rready = drr;
    endtask

    // Called just after a negedge with the inputs already applied.
    // It checks the outputs, steps the model across the posedge, and returns at the next negedge.
    task automatic cyc(input string tag);
        bit el_i, el_d, g_i, g_d, i_first;
        logic [ADDR_W-1:0] e_addr;
        el_i = ip.req && (!busy[0] || ip.rready);
        el_d = dp.req && (!busy[1] || dp.rready);
`ifdef ROM_ARB_RR_EN
        i_first = m_last_d;
`else
        i_first = 1'b1;
`endif
        g_i = el_i && (!el_d || i_first);
        g_d = el_d && !g_i;
        e_addr = g_i ? ip.addr : (g_d ? dp.addr : m_last);
        #1;
        chk({tag, ".i_rvalid"}, 32'(ip.rvalid), 32'(busy[0]));
        chk({tag, ".d_rvalid"}, 32'(dp.rvalid), 32'(busy[1]));
        chk({tag, ".i_rdata"},  ip.rdata, busy[0] ? exp_d[0] : 32'h0);
        chk({tag, ".d_rdata"},  dp.rdata, busy[1] ? exp_d[1] : 32'h0);
        chk({tag, ".i_gnt"},    32'(ip.gnt), 32'(g_i));
        chk({tag, ".d_gnt"},    32'(dp.gnt), 32'(g_d));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_addr));
        @(posedge clk);
        if (busy[0] && ip.rready) busy[0] = 0;
        if (busy[1] && dp.rready) busy[1] = 0;
        if (g_i) begin busy[0] = 1; exp_d[0] = rom[ip.addr]; end
        if (g_d) begin busy[1] = 1; exp_d[1] = rom[dp.addr]; end
        if (g_i || g_d) begin m_last = e_addr; m_last_d = g_d; end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) rom[a] = $urandom;
        rom[0] = 32'he3a00004; rom[1] = 32'he3a01001;
        rom[5] = 32'he0533112; rom[8] = 32'he12fff10;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        chk("reset.i_rvalid", 32'(ip.rvalid), 32'h0);
        chk("reset.i_rdata",  ip.rdata, 32'h0);
        chk("reset.rom_addr", 32'(rom_addr), 32'h0);
        rst_n = 1'b1;
        cyc("idle");

        // Single I fetch
        drive(1, 0, 1, 0, 0, 1); cyc("single.g");
        drive(0, 0, 1, 0, 0, 1); cyc("single.r");
        cyc("single.idle");

        // Back-to-back streaming
        drive(1, 0, 1, 0, 0, 1); cyc("stream0");
        drive(1, 1, 1, 0, 0, 1); cyc("stream1");
        drive(1, 5, 1, 0, 0, 1); cyc("stream5");
        drive(1, 8, 1, 0, 0, 1); cyc("stream8");
        drive(0, 0, 1, 0, 0, 1); cyc("stream.last");
        chk("stream.const", exp_d[0], 32'he12fff10);

        // Backpressure, with D served while I is stalled
        drive(1, 5, 0, 0, 0, 1); cyc("bp.g");
        drive(1, 1, 0, 0, 0, 1); cyc("bp.h1");
        drive(1, 1, 0, 0, 0, 1); cyc("bp.h2");
        drive(1, 1, 0, 0, 0, 1); cyc("bp.h3");
        chk("bp.i_rdata.const", ip.rdata, 32'he0533112);
        drive(0, 0, 0, 1, 8, 1); cyc("bp.dg");
        drive(0, 0, 1, 0, 0, 1); cyc("bp.dr");
        cyc("bp.idle");

        // Conflict between the two ports
        drive(1, 1, 1, 1, 8, 1);
        for (int k = 0; k < 6; k++) cyc("conflict");
        drive(0, 0, 1, 0, 0, 1); cyc("conflict.drain");
        cyc("conflict.idle");

        // Async reset during a held I response
        drive(1, 5, 0, 0, 0, 1); cyc("rst.g");
        drive(0, 0, 0, 0, 0, 1); cyc("rst.h");
        #2 rst_n = 1'b0;
        #1;
        chk("rst.i_rvalid", 32'(ip.rvalid), 32'h0);
        chk("rst.i_rdata",  ip.rdata, 32'h0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 0, 1);
        cyc("rst.idle0");
        cyc("rst.idle1");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 63), $urandom_range(0, 2) != 0);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
